// File: rtl/note_tone_player.sv
// Monophonic note player: accepts a 30-bit note word, picks its highest set bit,
// and sounds that note as a +/-AMP square wave for GATE_CYCLES clocks.
module note_tone_player #(
  parameter int unsigned        GATE_CYCLES = 12500000,
  parameter logic signed [15:0] AMP         = 16'sd8000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        note_in,
  input  logic               note_valid,
  input  logic               stop,
  output logic               note_ready,
  output logic signed [15:0] sample_out,
  output logic               tone_on,
  output logic [4:0]         note_idx
);

  localparam int unsigned GATE_W = 27;
  localparam int unsigned HALF_W = 19;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned WORD_W = 30;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;

  localparam logic [GATE_W-1:0]  GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   TOP_IDX   = IDX_W'(WORD_W - 1);
  localparam logic signed [15:0] AMP_NEG   = -AMP;

  logic [1:0]        state, state_nx;
  logic [WORD_W-1:0] word_r, word_nx;
  logic [IDX_W-1:0]  scan_idx, scan_nx;
  logic [IDX_W-1:0]  note_idx_nx;
  logic [HALF_W-1:0] half_cnt, half_nx;
  logic [GATE_W-1:0] gate_cnt, gate_nx;
  logic              level, level_nx;

  logic unused_note_hi;
  assign unused_note_hi = ^note_in[31:30];

  // Half-period in clk cycles for note index 6*fret+string.
  function automatic logic [HALF_W-1:0] hp_lookup(input logic [IDX_W-1:0] idx);
    case (idx)
      5'd0:    return 19'd75843;
      5'd1:    return 19'd101239;
      5'd2:    return 19'd127551;
      5'd3:    return 19'd170265;
      5'd4:    return 19'd227273;
      5'd5:    return 19'd303361;
      5'd6:    return 19'd71586;
      5'd7:    return 19'd95557;
      5'd8:    return 19'd120392;
      5'd9:    return 19'd160709;
      5'd10:   return 19'd214517;
      5'd11:   return 19'd286335;
      5'd12:   return 19'd67568;
      5'd13:   return 19'd90194;
      5'd14:   return 19'd113635;
      5'd15:   return 19'd151689;
      5'd16:   return 19'd202477;
      5'd17:   return 19'd270264;
      5'd18:   return 19'd63776;
      5'd19:   return 19'd85132;
      5'd20:   return 19'd107257;
      5'd21:   return 19'd143175;
      5'd22:   return 19'd191113;
      5'd23:   return 19'd255095;
      5'd24:   return 19'd60196;
      5'd25:   return 19'd80354;
      5'd26:   return 19'd101237;
      5'd27:   return 19'd135139;
      5'd28:   return 19'd180386;
      5'd29:   return 19'd240778;
      default: return 19'd0;
    endcase
  endfunction

  // Next-state and datapath updates.
  always_comb begin
    state_nx    = state;
    word_nx     = word_r;
    scan_nx     = scan_idx;
    note_idx_nx = note_idx;
    half_nx     = half_cnt;
    gate_nx     = gate_cnt;
    level_nx    = level;
    case (state)
      IDLE: begin
        if (note_valid && !stop) begin
          word_nx  = note_in[WORD_W-1:0];
          scan_nx  = TOP_IDX;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (word_r[scan_idx]) begin
          note_idx_nx = scan_idx;
          half_nx     = hp_lookup(scan_idx) - 19'd1;
          gate_nx     = GATE_LOAD;
          level_nx    = 1'b1;
          state_nx    = PLAY;
        end else if (scan_idx == '0) begin
          state_nx = IDLE;
        end else begin
          scan_nx = scan_idx - 5'd1;
        end
      end
      PLAY: begin
        if (half_cnt == '0) begin
          half_nx  = hp_lookup(note_idx) - 19'd1;
          level_nx = ~level;
        end else begin
          half_nx = half_cnt - 19'd1;
        end
        if (gate_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          gate_nx = gate_cnt - 27'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (stop) state_nx = IDLE;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      word_r     <= '0;
      scan_idx   <= TOP_IDX;
      note_idx   <= '0;
      half_cnt   <= '0;
      gate_cnt   <= '0;
      level      <= 1'b0;
      note_ready <= 1'b1;
      tone_on    <= 1'b0;
      sample_out <= '0;
    end else begin
      state      <= state_nx;
      word_r     <= word_nx;
      scan_idx   <= scan_nx;
      note_idx   <= note_idx_nx;
      half_cnt   <= half_nx;
      gate_cnt   <= gate_nx;
      level      <= level_nx;
      note_ready <= (state_nx == IDLE);
      tone_on    <= (state_nx == PLAY);
      sample_out <= (state_nx == PLAY) ? (level_nx ? AMP : AMP_NEG) : 16'sd0;
    end
  end

endmodule

// File: doc/note_tone_player.md
NOTE_TONE_PLAYER -- requirements
Module: note_tone_player

Interface
REQ-001 Parameter GATE_CYCLES, default 12500000, clk cycles each note sounds (250 ms at 50 MHz); legal range 1..2^27-1.
REQ-002 Parameter AMP, default 16'sd8000, square-wave amplitude magnitude.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 note_in  input  32  encoded note word: bit 6*f+s set means string s (0..5) is struck at fret position f (0..4); bits 31:30 are ignored.
REQ-006 note_valid  input  1  note_in is valid; transfer occurs on a clk edge where note_valid=1 and note_ready=1.
REQ-007 stop  input  1  abort: silence the output and return to idle.
REQ-008 note_ready  output  1  block accepts a note word; high only in IDLE.
REQ-009 sample_out  output  16  signed audio sample.
REQ-010 tone_on  output  1  high only in PLAY.
REQ-011 note_idx  output  5  bit index (0..29) of the note currently sounding; holds its last value outside PLAY.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and PLAY; all outputs SHALL be registered or decoded from registered state only.
REQ-013 IDLE: on transfer, latch note_in[29:0] into word_r, set scan_idx=29, and go to SCAN; with no transfer, stay in IDLE.
REQ-014 SCAN: evaluate one bit per cycle, word_r[scan_idx], moving from 29 down to 0.
REQ-015 SCAN, bit set: load note_idx=scan_idx, half_cnt=HP[scan_idx]-1, gate_cnt=GATE_CYCLES-1 and level=1, then go to PLAY.
REQ-016 SCAN, bit clear: if scan_idx=0, go to IDLE (empty word, no tone); otherwise decrement scan_idx.
REQ-017 Priority: the highest set bit (highest fret, then highest string) SHALL be played; all other set bits are discarded (monophonic).
REQ-018 Latency: for a word whose highest set bit is k, accepted at edge E0, PLAY SHALL be entered at edge E0+(30-k).
REQ-019 An all-zero word SHALL return to IDLE at E0+30 with tone_on never asserted.
REQ-020 PLAY: half_cnt decrements each cycle; at 0 it reloads HP[note_idx]-1 and level toggles.
REQ-021 PLAY: gate_cnt decrements each cycle; when gate_cnt=0, go to IDLE. Total PLAY duration is exactly GATE_CYCLES cycles.
REQ-022 sample_out SHALL be +AMP when in PLAY with level=1, -AMP when in PLAY with level=0, and 0 in every other state.
REQ-023 HP[6f+s] SHALL be the constant round(25000000 / (F[s]*2^(f/12))), with F = {329.63, 246.94, 196.00, 146.83, 110.00, 82.41} Hz for s=0..5.
REQ-024 Example HP values: HP[0]=75843, HP[5]=303361, HP[6]=71586.
REQ-025 HP SHALL be held in a 30-entry, 19-bit ROM/case table; indices 30 and 31 are unreachable.
REQ-026 note_valid in SCAN or PLAY SHALL be ignored (note_ready=0); the sender holds the word until it is accepted.
REQ-027 stop=1 in any state SHALL force IDLE on the next edge, with sample_out=0 and tone_on=0.
REQ-028 If stop and a transfer coincide in IDLE, stop wins and the word is not accepted.
REQ-029 All counters SHALL wrap-free: gate_cnt is 27 bits and half_cnt is 19 bits, with no underflow past 0.

Reset
REQ-030 When resetn=0 at a clk edge: state=IDLE, word_r=0, scan_idx=29, note_idx=0, half_cnt=0, gate_cnt=0, level=0.
REQ-031 Resulting outputs: note_ready=1, tone_on=0, sample_out=0.
REQ-032 Reset asserted mid-SCAN or mid-PLAY SHALL abandon the note immediately, and no residual tone may follow.
REQ-033 Reset SHALL take priority over stop and note_valid.

Verification (GATE_CYCLES=200000, AMP=8000)
REQ-034 Scenario 1: note_in=32'h00000001 accepted at E0 -> tone_on rises at E0+30, note_idx=0, sample_out=+8000; first toggle to -8000 after 75843 cycles; tone_on low after 200000 cycles; note_ready=1.
REQ-035 Scenario 2: note_in=32'h20000041 (bits 29, 6, 0) -> PLAY at E0+1, note_idx=29; the lower bits are never played.
REQ-036 Scenario 3: note_in=0 -> note_ready low for exactly 30 cycles; tone_on stays 0; sample_out stays 0.
REQ-037 Scenario 4: stop pulsed 1000 cycles into PLAY -> next edge IDLE, sample_out=0; a new word is accepted on the following cycle.
REQ-038 Scenario 5: note_valid held high with a second word during PLAY -> the second word is accepted on the first IDLE cycle, and its tone follows the first gate with no overlap.
REQ-039 Scenario 6: resetn=0 during SCAN and during PLAY -> all outputs match REQ-030 and REQ-031 on the next edge; bits 31:30 set alone behave as an empty word.
